// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: opcodes, FSM states and the
// boot image that the array takes on reset.
package imem_pkg;

    localparam logic [2:0] OpStore = 3'd1;
    localparam logic [2:0] OpLoad  = 3'd2;
    localparam logic [2:0] OpAddi  = 3'd3;
    localparam logic [2:0] OpBne   = 3'd4;

    typedef enum logic [1:0] {
        StRun,
        StLoad,
        StErr
    } imem_state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] arg;
    } boot_entry_t;

    localparam int unsigned BOOT_LEN = 5;

    localparam boot_entry_t BootImage [BOOT_LEN] = '{
        '{OpStore, 8'd30},
        '{OpLoad,  8'd30},
        '{OpAddi,  8'd2},
        '{OpStore, 8'd30},
        '{OpBne,   8'd1}
    };

endpackage

// File: rtl/imem_boot_if.sv
// Fetch port plus program-load stream of the instruction memory. The slave side is the
// memory; the master side is the processor fetch unit together with the loader.
interface imem_boot_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned OP_W   = 3
);
    localparam int unsigned AW = WORD_W - OP_W;

    logic [AW-1:0]     Iaddress;
    logic [WORD_W-1:0] Idata;
    logic              cpu_hold;
    logic              ld_start;
    logic              ld_valid;
    logic              ld_ready;
    logic [WORD_W-1:0] ld_data;
    logic              ld_last;
    logic              ld_error;
    logic [AW:0]       word_count;
    logic [WORD_W-1:0] ld_sum;

    modport slave (
        input  Iaddress, ld_start, ld_valid, ld_data, ld_last,
        output Idata, cpu_hold, ld_ready, ld_error, word_count, ld_sum
    );

    modport master (
        output Iaddress, ld_start, ld_valid, ld_data, ld_last,
        input  Idata, cpu_hold, ld_ready, ld_error, word_count, ld_sum
    );
endinterface

// File: rtl/imem_boot.sv
// Instruction memory initialised from the boot image on reset and reloadable at run time
// over a valid/ready stream; the processor is held while a load is in progress.
module imem_boot
    import imem_pkg::*;
#(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned OP_W   = 3,
    parameter int unsigned DEPTH  = 2 ** (WORD_W - OP_W)
) (
    input logic          clock,
    input logic          reset,
    imem_boot_if.slave   bus_io
);
    localparam int unsigned AW         = WORD_W - OP_W;
    localparam int unsigned IdxW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ResetCount = (BOOT_LEN < DEPTH) ? BOOT_LEN : DEPTH;

    imem_state_t       state_q, state_d;
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [AW:0]       wc_q, wc_d;
    logic [WORD_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;
    logic              ready;
    logic [WORD_W-1:0] idata;
    logic              beat;
    logic              at_end;

    function automatic logic [WORD_W-1:0] boot_word(input int unsigned i);
        if (i < BOOT_LEN) begin
            return {OP_W'(BootImage[i].op), AW'(BootImage[i].arg)};
        end
        return '0;
    endfunction

    assign beat   = bus_io.ld_valid && ready;
    assign at_end = (ptr_q == AW'(DEPTH - 1));

    // State register and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StRun;
            ptr_q   <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
            wc_q    <= (AW + 1)'(ResetCount);
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            wc_q    <= wc_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= boot_word(i);
            end
        end else if (beat) begin
            mem_q[ptr_q[IdxW-1:0]] <= bus_io.ld_data;
        end
    end

    // Next-state logic; a start pulse always wins over a beat in the same cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun, StErr: begin
                if (bus_io.ld_start) state_d = StLoad;
            end
            StLoad: begin
                if (bus_io.ld_start)               state_d = StLoad;
                else if (beat && bus_io.ld_last)   state_d = StRun;
                else if (beat && at_end)           state_d = StErr;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        ptr_d  = ptr_q;
        sum_d  = sum_q;
        wc_d   = wc_q;
        err_d  = err_q;
        if (bus_io.ld_start) begin
            ptr_d = '0;
            sum_d = '0;
            err_d = 1'b0;
        end else if (beat) begin
            ptr_d = ptr_q + AW'(1);
            sum_d = sum_q + bus_io.ld_data;
            if (bus_io.ld_last) begin
                wc_d = (AW + 1)'(ptr_q) + (AW + 1)'(1);
            end else if (at_end) begin
                err_d = 1'b1;
            end
        end
        hold_d = (state_d != StRun);
    end

    // Output logic: fetch is combinational and only live in RUN
    always_comb begin
        ready = 1'b0;
        idata = '0;
        unique case (state_q)
            StRun: begin
                if (32'(bus_io.Iaddress) < DEPTH) idata = mem_q[bus_io.Iaddress[IdxW-1:0]];
            end
            StLoad: ready = !bus_io.ld_start;
            default: ;
        endcase
    end

    assign bus_io.Idata      = idata;
    assign bus_io.ld_ready   = ready;
    assign bus_io.cpu_hold   = hold_q;
    assign bus_io.ld_error   = err_q;
    assign bus_io.word_count = wc_q;
    assign bus_io.ld_sum     = sum_q;

endmodule

// File: doc/imem_boot.md
# imem_boot

Loadable instruction memory for the basic processor, the parametrised successor to the fixed-program ROM. It holds a `DEPTH`-word program in a register array that is initialised from a default boot image on reset. A program loader can overwrite the array at run time over a valid/ready stream, and `cpu_hold` stalls the processor while a load is in progress. The block sits between the program-load source (testbench or host interface) and the processor's instruction fetch port.

## Interface
- `WORD_W`, 8, instruction width.
- `OP_W`, 3, opcode field width; address width `AW = WORD_W-OP_W`.
- `DEPTH`, `2**AW`, number of implemented words; legal range 1..`2**AW`.
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Iaddress`  in  AW  fetch address from the processor.
- `Idata`  out  WORD_W  instruction at `Iaddress`.
- `cpu_hold`  out  1  high: processor must not fetch or advance its PC.
- `ld_start`  in  1  single-cycle pulse that begins a new program load.
- `ld_valid`  in  1  load word present on `ld_data`.
- `ld_ready`  out  1  block accepts the word this cycle.
- `ld_data`  in  WORD_W  load word.
- `ld_last`  in  1  qualifies the final word of a load.
- `ld_error`  out  1  last load overflowed `DEPTH`.
- `word_count`  out  AW+1  number of words in the current program.
- `ld_sum`  out  WORD_W  modulo-2^WORD_W sum of the words accepted in the last load.

## Operation
- **States:** RUN, LOAD, ERR.
- **Reset:**
  - State returns to RUN.
  - The array takes the default image: word 0 `{STORE,30}`, 1 `{LOAD,30}`, 2 `{ADDI,2}`, 3 `{STORE,30}`, 4 `{BNE,1}`, all other words 0.
  - `word_count`=5, `ld_sum`=0, `ld_error`=0, write pointer=0.
  - Reset overrides any event in the same cycle, including mid-load.
- **RUN:**
  - `cpu_hold`=0, `ld_ready`=0.
  - `Idata` = `mem[Iaddress]` combinationally; it is 0 when `Iaddress >= DEPTH`.
  - `ld_start` → LOAD, pointer←0, `ld_sum`←0, `ld_error`←0.
- **LOAD:**
  - `cpu_hold`=1, `Idata`=0.
  - `ld_ready` = `!ld_start`.
  - Each beat (`ld_valid && ld_ready`) writes `mem[ptr]←ld_data`, then updates `ptr++` and `ld_sum += ld_data`.
  - Beat with `ld_last` → RUN, `word_count←ptr+1`.
  - Beat without `ld_last` at `ptr==DEPTH-1` → ERR; the word is still written.
  - `ld_start` during LOAD restarts the load: pointer←0, sum←0. Any beat in that cycle is not accepted because `ld_ready`=0.
  - `ld_last` without `ld_valid` is ignored.
- **ERR:**
  - `cpu_hold`=1, `ld_error`=1, `ld_ready`=0, `Idata`=0.
  - `ld_start` → LOAD with the same initialisation as from RUN.
- **Array contents:** words beyond the loaded program are not cleared; they keep their previous contents.
- **Width rules:** `ld_sum` wraps modulo 2^WORD_W. `word_count` spans 1..`DEPTH`, hence AW+1 bits.

## Timing
- Fetch read is combinational, with zero latency, matching the processor's existing fetch timing.
- A word written on edge N is readable after edge N; in practice it is first fetched in RUN.
- `ld_start` at edge N: `cpu_hold`=1 and `ld_ready`=1 from cycle N+1.
- Final beat at edge N: `cpu_hold`=0 in cycle N+1. The processor fetches the new program from then on, without a reset.
- Loader throughput: one word per cycle when `ld_valid` is held high.
- The loader must hold `ld_data` and `ld_last` stable while `ld_valid`=1 and `ld_ready`=0.
- All outputs except `Idata` and `ld_ready` are registered.

## Structure
- Package `imem_pkg` holds:
  - opcode constants, replacing the macro include;
  - the state enum `imem_state_t`;
  - the default boot image constant and its length `BOOT_LEN`=5.
- Single module; the FSM and pointer are small enough that no sub-module is needed.

## Test plan
- **Reset image:** reset, then read addresses 0..5 → `{STORE,30}`, `{LOAD,30}`, `{ADDI,2}`, `{STORE,30}`, `{BNE,1}`, 0. Also `word_count`=5 and `cpu_hold`=0.
- **Back-to-back load:** `ld_start`, then 3 words 0x21, 0x42, 0x63 with `ld_last` on the third → RUN one cycle after the last beat. Expect `word_count`=3, `ld_sum`=0xC6, addr 2 reads 0x63, and addr 3 still reads the old `{STORE,30}`.
- **Throttled load:** `ld_valid` toggling 1-0-1-0 → only cycles with `ld_valid`=1 write; `cpu_hold` stays 1 throughout.
- **Overflow:** `DEPTH`=8, feed 8 words without `ld_last` → ERR with `ld_error`=1, `ld_ready`=0 and word 7 written. A following `ld_start` clears `ld_error` and reloads.
- **Restart priority:** `ld_start` mid-load in the same cycle as a valid word → word not accepted, pointer back to 0, next beat writes address 0.
- **Reset mid-load:** reset after 2 beats → default image restored, state RUN, `word_count`=5, `ld_sum`=0.
